aes_ctr_stream: RTL

AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

---
 rtl/aes_ctr_stream.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_stream.sv
// AES-CTR keystream sequencer: hands LANES counter blocks per batch to an external cipher core
// and streams the results out. Define AES_CTR_STREAM_MSG_XOR_EN to XOR a message stream onto the keystream.
module aes_ctr_stream #(
   parameter int                  LANES    = 4,
   parameter int                  CTR_BITS = 32,
   parameter int                  CNT_BITS = 16,
   parameter logic [CTR_BITS-1:0] CTR_INIT = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [127-CTR_BITS:0] i_nonce,
   input  logic [CNT_BITS-1:0]   i_num_blocks,
   input  logic                  i_abort,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_core_start,
   output logic [LANES*128-1:0]  o_core_iv,
   input  logic                  i_core_done,
   input  logic [LANES*128-1:0]  i_core_out,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [LANES*128-1:0]  o_out_data,
   output logic [LANES-1:0]      o_out_keep,
   output logic                  o_out_last,
`ifdef AES_CTR_STREAM_MSG_XOR_EN
   input  logic                  i_msg_valid,
   output logic                  o_msg_ready,
   input  logic [LANES*128-1:0]  i_msg_data,
`endif
   output logic [2:0]            o_state
);

   // Stream handshake: a beat transfers on a rising edge with o_out_valid && i_out_ready (and i_msg_valid
   // when the XOR path is built in); once raised, o_out_valid and its payload hold until that transfer.
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FIN} state_t;

   localparam int                  W          = LANES * 128;
   localparam logic [CNT_BITS-1:0] LANES_CNT  = CNT_BITS'(LANES);
   localparam logic [CTR_BITS-1:0] LANES_CTR  = CTR_BITS'(LANES);

   state_t                r_state;
   state_t                w_next;
   logic [127-CTR_BITS:0] r_nonce;
   logic [CTR_BITS-1:0]   r_ctr_base;
   logic [CNT_BITS-1:0]   r_remaining;
   logic [W-1:0]          r_core_iv;
   logic [W-1:0]          r_ks;
   logic [LANES-1:0]      r_out_keep;
   logic                  r_out_last;
   logic                  r_out_valid;
   logic                  r_core_pend;
   logic                  r_done;

   logic                  w_fire;
   logic                  w_capture;
   logic                  w_last;
   logic [CNT_BITS-1:0]   w_issued;
   logic [LANES-1:0]      w_keep;
   logic                  w_abort;

   function automatic logic [W-1:0] build_iv(input logic [127-CTR_BITS:0] nonce,
                                             input logic [CTR_BITS-1:0]   base);
      logic [W-1:0] iv;
      iv = '0;
      for (int i = 0; i < LANES; i++) begin
         iv[i*128 +: 128] = {nonce, base + CTR_BITS'(i)};
      end
      return iv;
   endfunction

`ifdef AES_CTR_STREAM_MSG_XOR_EN
   assign w_fire      = r_out_valid & i_out_ready & i_msg_valid;
   assign o_msg_ready = r_out_valid & i_out_ready;
   assign o_out_data  = r_ks ^ (i_msg_data & {W{r_out_valid}});
`else
   assign w_fire      = r_out_valid & i_out_ready;
   assign o_out_data  = r_ks;
`endif

   assign w_abort  = i_abort && (r_state != S_IDLE);
   assign w_last   = (r_remaining <= LANES_CNT);
   assign w_issued = w_last ? r_remaining : LANES_CNT;

   // core_done is a pulse; if the output register is still occupied it is remembered in r_core_pend
   // and the capture waits, relying on core_out staying stable until the next core_start.
   assign w_capture = (r_state == S_WAIT) && (i_core_done || r_core_pend) &&
                      (!r_out_valid || w_fire) && !i_abort;

   always_comb begin
      w_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         w_keep[i] = (CNT_BITS'(i) < w_issued);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = (i_num_blocks == '0) ? S_FIN : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_capture) w_next = w_last ? S_DRAIN : S_ISSUE;
         S_DRAIN: if (w_fire) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_comb begin
      o_busy       = (r_state != S_IDLE);
      o_core_start = (r_state == S_ISSUE);
      o_state      = r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nonce     <= '0;
         r_ctr_base  <= '0;
         r_remaining <= '0;
         r_core_iv   <= '0;
         r_ks        <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_core_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIN) && !i_abort;
         if (w_abort) begin
            r_out_valid <= 1'b0;
            r_core_pend <= 1'b0;
         end else begin
            if (r_state == S_IDLE && i_start && i_num_blocks != '0) begin
               r_nonce     <= i_nonce;
               r_ctr_base  <= CTR_INIT;
               r_remaining <= i_num_blocks;
               r_core_iv   <= build_iv(i_nonce, CTR_INIT);
            end
            if (r_state == S_WAIT && i_core_done && !w_capture) r_core_pend <= 1'b1;
            if (w_capture) begin
               r_core_pend <= 1'b0;
               r_out_valid <= 1'b1;
               r_ks        <= i_core_out;
               r_out_keep  <= w_keep;
               r_out_last  <= w_last;
               r_ctr_base  <= r_ctr_base + LANES_CTR;
               r_remaining <= r_remaining - w_issued;
               if (!w_last) r_core_iv <= build_iv(r_nonce, r_ctr_base + LANES_CTR);
            end else if (w_fire) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   assign o_done      = r_done;
   assign o_core_iv   = r_core_iv;
   assign o_out_valid = r_out_valid;
   assign o_out_keep  = r_out_keep;
   assign o_out_last  = r_out_last;

endmodule
